// File: rtl/instruction_loader_pkg.sv
// rtl/instruction_loader_pkg.sv - shared state encoding, error bits and sizing helpers
package instruction_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int ERR_PARTIAL  = 0;
  localparam int ERR_OVERFLOW = 1;

  function automatic int calc_wpi(input int inst_bits, input int word_bits);
    return inst_bits / word_bits;
  endfunction

  function automatic int calc_beat_bits(input int wpi);
    return (wpi > 1) ? $clog2(wpi) : 1;
  endfunction

endpackage

// File: rtl/instruction_loader_word_packer.sv
// rtl/instruction_loader_word_packer.sv - assembles WPI stream words into one instruction
module instruction_loader_word_packer
  import instruction_loader_pkg::*;
#(
  parameter int INST_BITS = 128,
  parameter int WORD_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 beat,
  input  logic [WORD_BITS-1:0] data,
  output logic                 complete,
  output logic [INST_BITS-1:0] inst
);

  localparam int WPI = calc_wpi(INST_BITS, WORD_BITS);
  localparam int BB  = calc_beat_bits(WPI);

  logic [BB-1:0]        idx;
  logic [INST_BITS-1:0] buffer;

  // inst already contains the current beat, so the top can capture it on the final handshake
  always_comb begin
    inst = buffer;
    inst[idx*WORD_BITS +: WORD_BITS] = data;
  end

  assign complete = beat && (idx == BB'(WPI - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx    <= '0;
      buffer <= '0;
    end else if (clear) begin
      idx    <= '0;
      buffer <= '0;
    end else if (beat) begin
      buffer <= inst;
      idx    <= complete ? '0 : idx + BB'(1);
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - packs a word stream into instructions and writes instruction memory
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int INST_BITS = 128,
  parameter int WORD_BITS = 32,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [ADDR_BITS-1:0] end_addr,
  input  logic [WORD_BITS-1:0] s_tdata,
  input  logic                 s_tvalid,
  input  logic                 s_tlast,
  output logic                 s_tready,
  output logic                 wea,
  output logic [ADDR_BITS-1:0] addra,
  output logic [INST_BITS-1:0] din,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           error,
  output logic [ADDR_BITS:0]   inst_count
);

  state_t               state;
  logic                 start_q;
  logic [ADDR_BITS-1:0] ptr;
  logic [ADDR_BITS-1:0] end_q;
  logic                 wrapped;
  logic [ADDR_BITS:0]   ptr_inc;
  logic                 start_edge;
  logic                 accept;
  logic                 complete;
  logic [INST_BITS-1:0] packed_inst;

  assign start_edge = start && !start_q;
  assign accept     = s_tvalid && s_tready;
  assign ptr_inc    = {1'b0, ptr} + (ADDR_BITS+1)'(1);

  instruction_loader_word_packer #(
    .INST_BITS(INST_BITS),
    .WORD_BITS(WORD_BITS)
  ) u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start_edge && (state == ST_IDLE || state == ST_DONE)),
    .beat    (accept && state == ST_LOAD),
    .data    (s_tdata),
    .complete(complete),
    .inst    (packed_inst)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      start_q    <= 1'b0;
      ptr        <= '0;
      end_q      <= '0;
      wrapped    <= 1'b0;
      s_tready   <= 1'b0;
      wea        <= 1'b0;
      addra      <= '0;
      din        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= '0;
      inst_count <= '0;
    end else begin
      start_q <= start;
      wea     <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            ptr        <= start_addr;
            end_q      <= end_addr;
            wrapped    <= 1'b0;
            inst_count <= '0;
            error      <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            s_tready   <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (complete) begin
              if (!wrapped && ptr <= end_q) begin
                wea        <= 1'b1;
                addra      <= ptr;
                din        <= packed_inst;
                inst_count <= inst_count + (ADDR_BITS+1)'(1);
                // a carry out of the top address freezes the pointer instead of rolling to 0
                if (ptr_inc[ADDR_BITS]) wrapped <= 1'b1;
                else                    ptr     <= ptr_inc[ADDR_BITS-1:0];
                if (s_tlast) begin
                  state    <= ST_DONE;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  s_tready <= 1'b0;
                end
              end else begin
                error[ERR_OVERFLOW] <= 1'b1;
                if (s_tlast) begin
                  state    <= ST_DONE;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  s_tready <= 1'b0;
                end else begin
                  state <= ST_DRAIN;
                end
              end
            end else if (s_tlast) begin
              error[ERR_PARTIAL] <= 1'b1;
              state    <= ST_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              s_tready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (accept && s_tlast) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            s_tready <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
